// File: rtl/rx_block_fifo.sv
// Word-to-block staging FIFO: collects WORD_W-bit words and releases them
// WORDS_PER_BLOCK at a time as one wide block, first word in the top bits.
module rx_block_fifo #(
    parameter int WORD_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int BLOCK_DEPTH     = 1
) (
    input  logic                                clk,
    input  logic                                n_rst,
    input  logic                                write_en,
    input  logic [WORD_W-1:0]                   data_in,
    input  logic                                read_en,
    output logic [WORD_W*WORDS_PER_BLOCK-1:0]   data_out,
    output logic                                fifo_empty,
    output logic                                fifo_full
);

    localparam int TOTAL   = BLOCK_DEPTH * WORDS_PER_BLOCK;
    localparam int PTR_W   = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int CNT_W   = $clog2(TOTAL + 1);
    localparam int BLOCK_W = WORD_W * WORDS_PER_BLOCK;

    localparam logic [PTR_W-1:0] LAST_WORD  = PTR_W'(TOTAL - 1);
    localparam logic [PTR_W-1:0] LAST_BLOCK = PTR_W'(TOTAL - WORDS_PER_BLOCK);
    localparam logic [PTR_W-1:0] BLOCK_STEP = PTR_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] CNT_TOTAL  = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] CNT_BLOCK  = CNT_W'(WORDS_PER_BLOCK);

    logic [WORD_W-1:0]  mem [TOTAL];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               write_ok;
    logic               read_ok;
    logic [PTR_W-1:0]   wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [CNT_W-1:0]   count_next;
    logic [BLOCK_W-1:0] read_block;

    // Both strobes are qualified against the pre-edge occupancy, so a read
    // in the same cycle never makes room for a write that arrived while full.
    assign write_ok = write_en && !fifo_full;
    assign read_ok  = read_en && (count >= CNT_BLOCK);

    // Pointers wrap explicitly so depths that are not powers of two work.
    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (write_ok) begin
            wr_ptr_next = (wr_ptr == LAST_WORD) ? '0 : wr_ptr + PTR_W'(1);
        end
        if (read_ok) begin
            rd_ptr_next = (rd_ptr == LAST_BLOCK) ? '0 : rd_ptr + BLOCK_STEP;
        end
        case ({write_ok, read_ok})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_BLOCK;
            2'b11:   count_next = count + CNT_W'(1) - CNT_BLOCK;
            default: count_next = count;
        endcase
    end

    // Oldest word of the block lands in the most significant slice.
    always_comb begin
        read_block = '0;
        for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
            read_block[(WORDS_PER_BLOCK-1-i)*WORD_W +: WORD_W] = mem[rd_ptr + PTR_W'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (write_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Flags are registered from the next count so they never glitch.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            fifo_empty <= (count_next == '0);
            fifo_full  <= (count_next == CNT_TOTAL);
            if (read_ok) begin
                data_out <= read_block;
            end
        end
    end

endmodule

// File: tb/tb_rx_block_fifo.sv
// Scoreboard bench: one-block and two-block FIFOs share stimulus; a queue-based
// model predicts each cycle's outputs and a monitor compares them.
module tb_rx_block_fifo;

    logic         tb_clk;
    logic         n_rst;
    logic         write_en;
    logic [31:0]  data_in;
    logic         read_en;
    logic [127:0] data_out_a;
    logic         fifo_empty_a;
    logic         fifo_full_a;
    logic [127:0] data_out_b;
    logic         fifo_empty_b;
    logic         fifo_full_b;

    typedef struct packed {
        logic [127:0] dout_a;
        logic         empty_a;
        logic         full_a;
        logic [127:0] dout_b;
        logic         empty_b;
        logic         full_b;
    } expect_t;

    expect_t      exp_q[$];
    logic [31:0]  model_a[$];
    logic [31:0]  model_b[$];
    logic [127:0] last_a;
    logic [127:0] last_b;
    int           checks;
    int           errors;

    rx_block_fifo #(.WORD_W(32), .WORDS_PER_BLOCK(4), .BLOCK_DEPTH(1)) dut_a (
        .clk        (tb_clk),
        .n_rst      (n_rst),
        .write_en   (write_en),
        .data_in    (data_in),
        .read_en    (read_en),
        .data_out   (data_out_a),
        .fifo_empty (fifo_empty_a),
        .fifo_full  (fifo_full_a)
    );

    rx_block_fifo #(.WORD_W(32), .WORDS_PER_BLOCK(4), .BLOCK_DEPTH(2)) dut_b (
        .clk        (tb_clk),
        .n_rst      (n_rst),
        .write_en   (write_en),
        .data_in    (data_in),
        .read_en    (read_en),
        .data_out   (data_out_b),
        .fifo_empty (fifo_empty_b),
        .fifo_full  (fifo_full_b)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // A FIFO of words: a read pops four if at least four are held, a write
    // appends if below capacity; both judged on the pre-edge occupancy.
    task automatic step_model(input int inst, input int cap, input logic we,
                              input logic [31:0] din, input logic re, input logic rst);
        logic [31:0]  q[$];
        logic [127:0] last;
        bit           rd;
        bit           wr;
        if (inst == 0) begin
            q = model_a;
            last = last_a;
        end else begin
            q = model_b;
            last = last_b;
        end
        if (rst) begin
            q.delete();
            last = '0;
        end else begin
            rd = re && (q.size() >= 4);
            wr = we && (q.size() < cap);
            if (rd) begin
                last = {q[0], q[1], q[2], q[3]};
                for (int k = 0; k < 4; k++) void'(q.pop_front());
            end
            if (wr) q.push_back(din);
        end
        if (inst == 0) begin
            model_a = q;
            last_a = last;
        end else begin
            model_b = q;
            last_b = last;
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic [31:0] din,
                                  input logic re, input logic rst);
        expect_t e;
        @(negedge tb_clk);
        write_en = we;
        data_in  = din;
        read_en  = re;
        n_rst    = rst;
        step_model(0, 4, we, din, re, rst);
        step_model(1, 8, we, din, re, rst);
        e.dout_a  = last_a;
        e.empty_a = (model_a.size() == 0);
        e.full_a  = (model_a.size() == 4);
        e.dout_b  = last_b;
        e.empty_b = (model_b.size() == 0);
        e.full_b  = (model_b.size() == 8);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic write_word(input logic [31:0] w);
        apply_stimulus(1'b1, w, 1'b0, 1'b0);
    endtask

    task automatic check_output(input string name, input logic [127:0] actual,
                                input logic [127:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    // Monitor: every edge driven by the stimulus has one queued expectation.
    initial begin
        expect_t e;
        forever begin
            @(posedge tb_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("data_out_a",   data_out_a,            e.dout_a);
                check_output("fifo_empty_a", {127'b0, fifo_empty_a}, {127'b0, e.empty_a});
                check_output("fifo_full_a",  {127'b0, fifo_full_a},  {127'b0, e.full_a});
                check_output("data_out_b",   data_out_b,            e.dout_b);
                check_output("fifo_empty_b", {127'b0, fifo_empty_b}, {127'b0, e.empty_b});
                check_output("fifo_full_b",  {127'b0, fifo_full_b},  {127'b0, e.full_b});
            end
        end
    end

    initial begin
        logic [31:0] first_blk  [4] = '{32'hdeb0f813, 32'h41f3503a, 32'h7cd01e2b, 32'hc7cdd556};
        logic [31:0] second_blk [4] = '{32'h7D8AE0F7, 32'hCFA0A6CB, 32'h09FB5D05, 32'hA8EC586D};
        int          drain;
        checks   = 0;
        errors   = 0;
        n_rst    = 1'b1;
        write_en = 1'b0;
        read_en  = 1'b0;
        data_in  = '0;
        last_a   = '0;
        last_b   = '0;

        $display("[TB] reset and first block with gapped writes");
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            write_word(first_blk[i]);
            idle(1);
        end
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        idle(3);

        $display("[TB] refill, overflow word, read");
        for (int i = 0; i < 4; i++) write_word(second_blk[i]);
        write_word(32'hFFFFFFFF);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        idle(2);

        $display("[TB] short read ignored, reset mid-block, fresh block");
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) write_word($urandom);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        idle(1);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        idle(1);
        for (int i = 0; i < 4; i++) write_word(32'h1000_0000 + 32'(i));
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        idle(1);

        $display("[TB] two-block depth, wrap and simultaneous read/write");
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) write_word(32'h2000_0000 + 32'(i));
        apply_stimulus(1'b1, 32'hEEEE_EEEE, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) write_word(32'h3000_0000 + 32'(i));
        apply_stimulus(1'b1, 32'h3000_0007, 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'h3000_0008, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        idle(2);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus($urandom_range(0, 99) < 60, $urandom,
                           $urandom_range(0, 99) < 25, $urandom_range(0, 249) == 0);
        end
        idle(2);

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge tb_clk);
            drain++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_block_fifo.md
# rx_block_fifo

Receive-side staging FIFO that accepts 32-bit words one at a time and releases them as 128-bit blocks for the AES-128 datapath. Four consecutive words form one block. The first word written becomes the most significant 32 bits of the block. The block sits between the word-wide host/bus interface and the 128-bit `dataPacketIn` input of the AES top level.

## Interface
Parameters:
- `WORD_W`, default 32: input word width.
- `WORDS_PER_BLOCK`, default 4: words per output block. Output width is `WORD_W*WORDS_PER_BLOCK` = 128.
- `BLOCK_DEPTH`, default 1: number of complete blocks stored. Legal range 1–8.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `n_rst`, in, 1: reset. One clock; reset is synchronous and active-high. The port keeps the codebase name `n_rst`, but it asserts high and is sampled on `clk`.
- `write_en`, in, 1: enqueue `data_in` this cycle.
- `data_in`, in, 32: word to enqueue.
- `read_en`, in, 1: dequeue the oldest complete block this cycle.
- `data_out`, out, 128: last dequeued block, registered and held.
- `fifo_empty`, out, 1: no words stored.
- `fifo_full`, out, 1: `BLOCK_DEPTH*WORDS_PER_BLOCK` words stored.

## Operation
- Storage is a circular buffer of `BLOCK_DEPTH*WORDS_PER_BLOCK` words with a write pointer, a read pointer (block-aligned) and a word count.
- The write pointer wraps modulo the total depth. The read pointer advances by `WORDS_PER_BLOCK` and wraps.
- **Write:**
  - A write happens if `write_en`=1 and `fifo_full`=0, as sampled at the edge. The word is stored at the write pointer, the pointer increments and the count increments.
  - A write while full is dropped silently. Contents, pointers and count are unchanged.
- **Read:**
  - A read happens if `read_en`=1 and count ≥ `WORDS_PER_BLOCK`, as sampled at the edge.
  - On a read, `data_out` ← {word[rp], word[rp+1], word[rp+2], word[rp+3]}, with word[rp] in bits [127:96].
  - The read pointer then advances one block and the count drops by `WORDS_PER_BLOCK`.
  - A read when fewer than 4 words are stored is ignored, and `data_out` holds its value.
- **Simultaneous read and write:** both are evaluated against the pre-edge count and both may take effect in the same cycle.
  - A write while full is still dropped, even if a read occurs in the same cycle.
  - The count update is net: +1 for the write, −`WORDS_PER_BLOCK` for the read.
- **Flags:** `fifo_empty` = (count==0) and `fifo_full` = (count==total depth). Both are decoded from registered state and are glitch-free.
- **Holding behaviour:** `data_out` changes only on a successful read or on reset. It is never cleared by emptying.
- **Reset:** count, pointers and `data_out` all go to 0. Stored words need not be cleared.
- **Reset mid-operation:** a partially written block is discarded, and the flags return to `fifo_empty`=1, `fifo_full`=0 on the next edge.

## Timing
- Reset values: `data_out`=128'h0, `fifo_empty`=1, `fifo_full`=0.
- Write latency: flags reflect the write immediately after the accepting edge.
  - With `BLOCK_DEPTH`=1, `fifo_full` rises after the edge that accepts the 4th word.
- Read latency: one edge. `data_out` is valid just after the edge that samples `read_en`=1, and the flags update on that same edge.
- Strobes are level-sampled per edge. `write_en` held for N cycles enqueues N words, until full.
- No handshake acknowledge exists. Callers gate their strobes with `fifo_full` and `fifo_empty`.
- Throughput: one word written per cycle, and one block read per cycle when blocks are available.

## Test plan
- Assert `n_rst`=1 for one edge → `fifo_empty`=1, `fifo_full`=0, `data_out`=0.
- Write 32'hdeb0f813, 32'h41f3503a, 32'h7cd01e2b, 32'hc7cdd556 with single-cycle `write_en` pulses and idle cycles between them → `fifo_full`=1 and `fifo_empty`=0 after the 4th write.
- Pulse `read_en` one cycle → `data_out`=128'hdeb0f81341f3503a7cd01e2bc7cdd556, `fifo_empty`=1, `fifo_full`=0. `data_out` must hold over the following idle cycles.
- Refill with 32'h7D8AE0F7, 32'hCFA0A6CB, 32'h09FB5D05, 32'hA8EC586D, then write a 5th word 32'hFFFFFFFF while full, then read → `data_out`=128'h7D8AE0F7CFA0A6CB09FB5D05A8EC586D and the extra word is not stored (`fifo_empty`=1).
- Write 3 words and pulse `read_en` → read ignored, `data_out` unchanged, `fifo_empty`=0. Then assert `n_rst` → `fifo_empty`=1. Then write 4 new words and read → only the new words appear.
- With `BLOCK_DEPTH`=2, write 8 words, then read twice. Then write 4 more with pointer wrap and read, and also assert `read_en`+`write_en` in the same cycle → blocks come out in FIFO order, and the simultaneous read and write both take effect.
